// File: rtl/glyph_pkg.sv
// Shared constants and encodings for the glyph layer renderer.
package glyph_pkg;

  // Default background colour; also driven during blanking.
  localparam logic [23:0] BG_RGB_DEFAULT = 24'hf8f9fa;

  // Per-layer log2 magnification.
  typedef enum logic [1:0] {
    SCALE_X1 = 2'd0,
    SCALE_X2 = 2'd1,
    SCALE_X4 = 2'd2,
    SCALE_X8 = 2'd3
  } scale_e;

  // Width of hit_layer for a given layer count; the all-ones code means
  // "no layer won" (background or blanking).
  function automatic int unsigned hit_layer_width(input int unsigned n_layers);
    return $clog2(n_layers) + 1;
  endfunction

endpackage

// File: rtl/glyph_layer_hit.sv
// Combinational hit test for one glyph layer: box test plus bitmap lookup.
module glyph_layer_hit
  import glyph_pkg::*;
#(
  parameter int unsigned GLYPH_W = 8,
  parameter int unsigned GLYPH_H = 8,
  parameter int unsigned CW      = 10
) (
  input  logic [CW-1:0]              hcount,
  input  logic [CW-1:0]              vcount,
  input  logic [CW-1:0]              x,
  input  logic [CW-1:0]              y,
  input  scale_e                     scale,
  input  logic [GLYPH_W*GLYPH_H-1:0] glyph,
  input  logic                       en,
  input  logic                       blink,
  input  logic                       blink_phase,
  output logic                       hit
);

  localparam int unsigned EW = CW + 4;
  localparam int unsigned NB = GLYPH_W * GLYPH_H;
  localparam logic [EW-1:0] W_EXT = EW'(GLYPH_W);
  localparam logic [EW-1:0] H_M1  = EW'(GLYPH_H - 1);
  localparam logic [EW-1:0] H_EXT = EW'(GLYPH_H);

  logic [EW-1:0] hc, vc, x_lo, y_lo, x_end, y_end, dx, dy, col, row, bit_pos;
  logic          inside_x, inside_y, pix_on;

  // Extended-width box test so far edges clip instead of wrapping.
  always_comb begin
    hc       = EW'(hcount);
    vc       = EW'(vcount);
    x_lo     = EW'(x);
    y_lo     = EW'(y);
    x_end    = x_lo + (W_EXT << scale);
    y_end    = y_lo + (H_EXT << scale);
    inside_x = (hc >= x_lo) && (hc < x_end);
    inside_y = (vc >= y_lo) && (vc < y_end);
    dx       = hc - x_lo;
    dy       = vc - y_lo;
    col      = dx >> scale;
    row      = dy >> scale;
    // Row 0 sits in the MSB row of the slice; column c is bit c of its row.
    bit_pos  = (H_M1 - row) * W_EXT + col;
    pix_on   = |(glyph & (NB'(1) << bit_pos));
    hit      = en & inside_x & inside_y & pix_on & ~(blink & blink_phase);
  end

endmodule

// File: rtl/glyph_layer_renderer.sv
// Multi-layer glyph compositor: frame-synchronised shadows, 2-stage pipeline.
module glyph_layer_renderer
  import glyph_pkg::*;
#(
  parameter int unsigned N_LAYERS  = 4,
  parameter int unsigned GLYPH_W   = 8,
  parameter int unsigned GLYPH_H   = 8,
  parameter int unsigned CW        = 10,
  parameter int unsigned BLINK_BIT = 4,
  parameter logic [23:0] BG_RGB    = BG_RGB_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  bright,
  input  logic [CW-1:0]                         hcount,
  input  logic [CW-1:0]                         vcount,
  input  logic                                  frame_start,
  input  logic [N_LAYERS*GLYPH_W*GLYPH_H-1:0]   glyph_in,
  input  logic [N_LAYERS*CW-1:0]                x_in,
  input  logic [N_LAYERS*CW-1:0]                y_in,
  input  logic [N_LAYERS*2-1:0]                 scale_in,
  input  logic [N_LAYERS*24-1:0]                color_in,
  input  logic [N_LAYERS-1:0]                   en_in,
  input  logic [N_LAYERS-1:0]                   blink_in,
  output logic [23:0]                           rgb,
  output logic                                  rgb_bright,
  output logic [$clog2(N_LAYERS):0]             hit_layer
);

  localparam int unsigned NB  = GLYPH_W * GLYPH_H;
  localparam int unsigned HLW = hit_layer_width(N_LAYERS);

  logic [N_LAYERS*NB-1:0] glyph_q, glyph_d;
  logic [N_LAYERS*CW-1:0] x_q, x_d, y_q, y_d;
  logic [N_LAYERS*2-1:0]  scale_q, scale_d;
  logic [N_LAYERS*24-1:0] color_q, color_d;
  logic [N_LAYERS-1:0]    en_q, en_d, blink_q, blink_d;
  logic [5:0]             frame_cnt_q, frame_cnt_d;

  logic [N_LAYERS-1:0]    hit_vec;
  logic [N_LAYERS-1:0]    hit_vec_q, hit_vec_d;
  logic                   bright_d1_q, bright_d1_d;

  logic [23:0]            rgb_q, rgb_d;
  logic [HLW-1:0]         hit_layer_q, hit_layer_d;
  logic                   rgb_bright_q, rgb_bright_d;
  logic                   found;

  // Capture layer parameters and advance the frame counter on frame_start.
  always_comb begin
    glyph_d     = glyph_q;
    x_d         = x_q;
    y_d         = y_q;
    scale_d     = scale_q;
    color_d     = color_q;
    en_d        = en_q;
    blink_d     = blink_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start) begin
      glyph_d     = glyph_in;
      x_d         = x_in;
      y_d         = y_in;
      scale_d     = scale_in;
      color_d     = color_in;
      en_d        = en_in;
      blink_d     = blink_in;
      frame_cnt_d = frame_cnt_q + 6'd1;
    end
  end

  // Shadow and frame counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glyph_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      scale_q     <= '0;
      color_q     <= '0;
      en_q        <= '0;
      blink_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      glyph_q     <= glyph_d;
      x_q         <= x_d;
      y_q         <= y_d;
      scale_q     <= scale_d;
      color_q     <= color_d;
      en_q        <= en_d;
      blink_q     <= blink_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  for (genvar k = 0; k < N_LAYERS; k++) begin : g_layer
    glyph_layer_hit #(
      .GLYPH_W (GLYPH_W),
      .GLYPH_H (GLYPH_H),
      .CW      (CW)
    ) u_hit (
      .hcount      (hcount),
      .vcount      (vcount),
      .x           (x_q[k*CW +: CW]),
      .y           (y_q[k*CW +: CW]),
      .scale       (scale_e'(scale_q[k*2 +: 2])),
      .glyph       (glyph_q[k*NB +: NB]),
      .en          (en_q[k]),
      .blink       (blink_q[k]),
      .blink_phase (frame_cnt_q[BLINK_BIT]),
      .hit         (hit_vec[k])
    );
  end

  // S1 next state: per-layer hits and bright for the current pixel.
  always_comb begin
    hit_vec_d   = hit_vec;
    bright_d1_d = bright;
  end

  // S2 next state: strict priority, lowest index wins; blanking forces background.
  always_comb begin
    rgb_d        = BG_RGB;
    hit_layer_d  = '1;
    rgb_bright_d = bright_d1_q;
    found        = 1'b0;
    for (int unsigned k = 0; k < N_LAYERS; k++) begin
      if (bright_d1_q && !found && hit_vec_q[k]) begin
        found       = 1'b1;
        rgb_d       = color_q[k*24 +: 24];
        hit_layer_d = HLW'(k);
      end
    end
  end

  // Pipeline registers S1 and S2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_vec_q    <= '0;
      bright_d1_q  <= 1'b0;
      rgb_q        <= BG_RGB;
      hit_layer_q  <= '1;
      rgb_bright_q <= 1'b0;
    end else begin
      hit_vec_q    <= hit_vec_d;
      bright_d1_q  <= bright_d1_d;
      rgb_q        <= rgb_d;
      hit_layer_q  <= hit_layer_d;
      rgb_bright_q <= rgb_bright_d;
    end
  end

  assign rgb        = rgb_q;
  assign hit_layer  = hit_layer_q;
  assign rgb_bright = rgb_bright_q;

endmodule
